phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Single-clock replacement for the PLL-derived four-phase clocking (pclk/uclk/rclk/wclk) of the slug core.
- Generates one-hot phase enables plus per-phase commit strobes from sysclk, so the core runs on one clock domain.
- Generalised in phase count and phase length; adds run/halt/single-step control, stall (wait-state) insertion and a completed-sequence counter, none of which the fixed PLL scheme provides.

Parameters:
NUM_PHASES, 4, phases per machine cycle (>=2)
PHASE_CYCLES, 2, sysclk cycles per phase (>=1)
COUNT_W, 32, width of completed-sequence counter

Ports:
sysclk  input  1  single system clock, rising edge
rst  input  1  asynchronous reset, active-low
run  input  1  level; 1 = free-run sequences
step  input  1  pulse; execute exactly one full sequence when halted
stall  input  1  level; freeze current phase (wait state)
phase_en  output  NUM_PHASES  one-hot active phase, all-zero when halted
phase_last  output  NUM_PHASES  one-hot commit strobe on final cycle of a phase
busy  output  1  1 while a sequence is in progress
halted  output  1  1 in IDLE
seq_count  output  COUNT_W  completed sequences, wraps modulo 2^COUNT_W

Behaviour:
- Reset (rst=0, async): state=IDLE, phase index p=0, sub-counter sub=0, phase_en=0, busy=0, halted=1, seq_count=0. phase_last=0 during reset.
- States: IDLE, RUN, STEP. sub width clog2(PHASE_CYCLES) (min 1); p width clog2(NUM_PHASES) (min 1).
- IDLE: run=1 sampled at edge t -> RUN; phase_en=1<<0 from cycle t+1. Else step=1 -> STEP, same timing. run and step both 1 -> RUN (run wins). stall ignored in IDLE.
- RUN/STEP: phase_en = 1<<p (registered), busy=1, halted=0.
- Each edge with stall=0: if sub<PHASE_CYCLES-1, sub++. Else sub=0 and advance p.
- Each edge with stall=1: sub, p, phase_en, state and seq_count all held.
- phase_last is a combinational decode: phase_en & {NUM_PHASES{sub==PHASE_CYCLES-1 && !stall}}. It is exactly one cycle wide per phase and is deferred while stalled.
- End of sequence (p=NUM_PHASES-1, sub=last, stall=0):
  - seq_count++, wrapping at 2^COUNT_W-1 -> 0.
  - RUN with run=1 -> p=0, next sequence starts back-to-back with no gap cycle.
  - RUN with run=0 -> IDLE; phase_en=0, halted=1 on the next cycle.
  - STEP -> IDLE always.
- Halting only takes effect at a sequence boundary: run dropping mid-sequence completes the current sequence.
- step asserted in RUN or STEP is ignored; it is not queued.
- A step held high in IDLE after a STEP completes starts another sequence, one per return to IDLE. Callers pulse step.
- PHASE_CYCLES=1: phase_last equals phase_en whenever stall=0.
- Reset asserted mid-sequence: outputs go immediately to reset values; the partial sequence is not counted.
- Per-sequence length without stalls: NUM_PHASES*PHASE_CYCLES cycles. Each stall cycle adds exactly one cycle.

Test Plan:
(All with NUM_PHASES=4, PHASE_CYCLES=2, COUNT_W=8.)
- Reset then run=1 at edge 0 -> phase_en sequence 0001,0001,0010,0010,0100,0100,1000,1000 from cycle 1. phase_last=0001 on cycle 2 only. seq_count=1 after cycle 8. Phase_en=0001 again at cycle 9.
- Halted, step pulse one cycle -> exactly one 8-cycle sequence, then phase_en=0, halted=1, seq_count incremented by 1. A second step pulse during the sequence is ignored.
- Running, stall=1 for 3 cycles while phase_en=0100 and sub=1 -> phase_en held 0100 for 4 cycles total. phase_last=0100 only on the cycle stall falls. Sequence length is 11.
- run dropped at cycle 3 of a sequence -> sequence completes through phase_en=1000, then halted=1. seq_count +1, no further phases.
- rst driven low mid-phase 0010 -> phase_en=0, phase_last=0, seq_count=0 immediately, without waiting for a clock edge. Release with run=1 -> restarts at 0001.
- Force seq_count to 255 via 255 runs -> next completed sequence gives seq_count=0. Also check run=1 and step=1 together in IDLE enters RUN.

Source files
------------

// File: rtl/phase_sequencer.sv
// Single-clock phase sequencer: one-hot phase enables plus per-phase commit strobes,
// with run/halt/single-step control, stall insertion and a completed-sequence counter.
module phase_sequencer #(
  parameter int NUM_PHASES   = 4,
  parameter int PHASE_CYCLES = 2,
  parameter int COUNT_W      = 32
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  input  logic                  stall,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [NUM_PHASES-1:0] phase_last,
  output logic                  busy,
  output logic                  halted,
  output logic [COUNT_W-1:0]    seq_count
);

  localparam int SUB_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int P_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(PHASE_CYCLES - 1);
  localparam logic [P_W-1:0]        P_LAST   = P_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] FIRST_EN = NUM_PHASES'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_ST = 2'd1,
    STEP_ST = 2'd2
  } state_t;

  state_t           state_r;
  logic [SUB_W-1:0] sub_r;
  logic [P_W-1:0]   p_r;
  logic             sub_last_s;

  assign sub_last_s = (sub_r == SUB_LAST);

  // Commit strobe is combinational so a stall defers it to the cycle the stall drops.
  assign phase_last = phase_en & {NUM_PHASES{sub_last_s && !stall}};

  // Sequencer state, phase/sub counters, registered enables and sequence counter.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      sub_r     <= '0;
      p_r       <= '0;
      phase_en  <= '0;
      busy      <= 1'b0;
      halted    <= 1'b1;
      seq_count <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          sub_r <= '0;
          p_r   <= '0;
          if (run || step) begin
            // run has priority over step when both are seen together
            state_r  <= run ? RUN_ST : STEP_ST;
            phase_en <= FIRST_EN;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end else begin
            phase_en <= '0;
            busy     <= 1'b0;
            halted   <= 1'b1;
          end
        end
        RUN_ST, STEP_ST: begin
          if (stall) begin
            sub_r <= sub_r;
          end else if (!sub_last_s) begin
            sub_r <= sub_r + SUB_W'(1);
          end else if (p_r != P_LAST) begin
            sub_r    <= '0;
            p_r      <= p_r + P_W'(1);
            phase_en <= {phase_en[NUM_PHASES-2:0], 1'b0};
          end else begin
            sub_r     <= '0;
            p_r       <= '0;
            seq_count <= seq_count + COUNT_W'(1);
            if ((state_r == RUN_ST) && run) begin
              phase_en <= FIRST_EN;
            end else begin
              state_r  <= IDLE;
              phase_en <= '0;
              busy     <= 1'b0;
              halted   <= 1'b1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          sub_r    <= '0;
          p_r      <= '0;
          phase_en <= '0;
          busy     <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Table-driven, scoreboarded bench for phase_sequencer (4 phases x 2 cycles, 8-bit counter).
module tb_phase_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic       step;
  logic       stall;
  logic [3:0] phase_en;
  logic [3:0] phase_last;
  logic       busy;
  logic       halted;
  logic [7:0] seq_count;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic       run;
    logic       step;
    logic       stall;
    logic [3:0] en;
    logic [3:0] last;
    logic       busy;
    logic       halted;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  phase_sequencer #(
    .NUM_PHASES(4),
    .PHASE_CYCLES(2),
    .COUNT_W(8)
  ) dut (
    .sysclk(clk),
    .rst(rst),
    .run(run),
    .step(step),
    .stall(stall),
    .phase_en(phase_en),
    .phase_last(phase_last),
    .busy(busy),
    .halted(halted),
    .seq_count(seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, req);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic t, input logic [3:0] en,
                     input logic [3:0] last, input logic b, input logic h, input logic [7:0] c);
    vec_t v;
    v = '{run: r, step: s, stall: t, en: en, last: last, busy: b, halted: h, cnt: c};
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs at the falling edge, queue its expectation, then check it.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    run   = v.run;
    step  = v.step;
    stall = v.stall;
    exp_q.push_back(v);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("phase_en", idx, 32'(phase_en), 32'(e.en));
      chk("phase_last", idx, 32'(phase_last), 32'(e.last));
      chk("busy", idx, 32'(busy), 32'(e.busy));
      chk("halted", idx, 32'(halted), 32'(e.halted));
      chk("seq_count", idx, 32'(seq_count), 32'(e.cnt));
    end
  endtask

  initial begin
    vec_t v;
    int   pidx;
    tests_run    = 0;
    tests_failed = 0;

    // run=1 from idle: 8-cycle sequence, back-to-back restart
    add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'd0);
    // second sequence with 3 stall cycles on the last cycle of phase 2 (11 cycles)
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'd1);
    // third sequence: run drops on its third cycle, sequence still completes
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd2);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd3);
    // single step (stall ignored in idle), second step mid-sequence ignored
    add(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd4);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd4);
    // run and step together: RUN wins, so the next sequence follows back-to-back
    add(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'd4);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd5);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'd5);

    rst   = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase_en", 0, 32'(phase_en), 32'd0);
    chk("rst_phase_last", 0, 32'(phase_last), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_halted", 0, 32'(halted), 32'd1);
    chk("rst_seq_count", 0, 32'(seq_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // async reset mid-phase 0010, on its commit cycle
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_rst_phase_en", 0, 32'(phase_en), 32'b0010);
    chk("pre_rst_phase_last", 0, 32'(phase_last), 32'b0010);
    rst = 1'b0;
    #1;
    chk("async_rst_phase_en", 0, 32'(phase_en), 32'd0);
    chk("async_rst_phase_last", 0, 32'(phase_last), 32'd0);
    chk("async_rst_seq_count", 0, 32'(seq_count), 32'd0);
    chk("async_rst_halted", 0, 32'(halted), 32'd1);
    chk("async_rst_busy", 0, 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;

    // free-run 256 sequences from reset: counter reaches 255 then wraps to 0
    for (int c = 1; c <= 2049; c++) begin
      pidx   = ((c - 1) / 2) % 4;
      v.run    = 1'b1;
      v.step   = 1'b0;
      v.stall  = 1'b0;
      v.en     = 4'b0001 << pidx;
      v.last   = (((c - 1) % 2) == 1) ? v.en : 4'b0000;
      v.busy   = 1'b1;
      v.halted = 1'b0;
      v.cnt    = 8'((c - 1) / 8);
      apply(v, 1000 + c);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
